regfile_mux_np: RTL and testbench
=================================

Name: regfile_mux_np

Overview:
- Parametrised, registered register-file read/write block with NUM_RD independent read ports.
- Each read port is a DEPTH-to-1 selector with optional same-cycle write bypass and an optional hard-wired zero at entry 0.
- A handshaked dump port walks all entries one per accepted beat, so bench monitors and debug logic can observe the whole file.
- Sits in the decode stage between the instruction field decode and the ID/EX pipeline register.

Parameters:
- WIDTH, 32, data width of each entry.
- DEPTH, 32, number of entries (2..2**ADDR_W).
- ADDR_W, 5, address width of wa, each ra slice and dump_addr.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to rdata.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- we, input, 1, write enable.
- wa, input, ADDR_W, write address.
- wd, input, WIDTH, write data.
- rd_en, input, 1, capture all read ports this cycle.
- ra, input, NUM_RD*ADDR_W, read addresses; port i = ra[i*ADDR_W +: ADDR_W].
- rdata, output, NUM_RD*WIDTH, registered read data; port i = rdata[i*WIDTH +: WIDTH].
- rvalid, output, 1, rdata updated on the previous edge.
- dump_start, input, 1, request a full sweep.
- dump_ready, input, 1, consumer accepts the current dump beat.
- dump_valid, output, 1, dump beat present.
- dump_addr, output, ADDR_W, entry index of the current beat.
- dump_data, output, WIDTH, contents of entry dump_addr.
- dump_busy, output, 1, sweep in progress.
- dump_done, output, 1, one-cycle pulse after the last beat is accepted.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - All DEPTH entries, rdata, rvalid, dump_valid, dump_addr, dump_busy and dump_done go to 0.
  - FSM goes to IDLE.
  - Reset overrides every other input in the same cycle, including we and any in-progress sweep.
- Write:
  - On an edge with we=1, entry wa <= wd.
  - The write is ignored when wa >= DEPTH, or when ZERO_REG=1 and wa=0.
- Read (latency 1):
  - On an edge with rd_en=1, rdata port i is loaded from ra_i and rvalid <= 1.
  - On an edge with rd_en=0, rvalid <= 0 and rdata holds its value.
- Read value for port i, in priority order:
  1. ra_i >= DEPTH -> 0.
  2. ZERO_REG=1 and ra_i=0 -> 0.
  3. BYPASS=1, we=1, wa=ra_i, and the write is not ignored -> wd.
  4. Otherwise -> stored entry ra_i, as of before this edge.
- BYPASS=0: a same-edge read of the written address returns the old value.
- Duplicate read addresses across ports are legal and return identical data.
- Dump FSM states are IDLE, SWEEP and DONE.
  - IDLE: dump_valid=0, dump_busy=0. dump_start=1 -> SWEEP with dump_addr=0.
  - SWEEP:
    - dump_valid=1 and dump_busy=1.
    - dump_data is combinational from the stored entry dump_addr. It reflects writes committed on earlier edges, and 0 for entry 0 when ZERO_REG=1.
    - A beat is accepted when dump_valid and dump_ready are both 1 on an edge.
    - On acceptance with dump_addr < DEPTH-1: dump_addr increments.
    - On acceptance with dump_addr = DEPTH-1: go to DONE, dump_valid=0.
    - With dump_ready=0: dump_addr holds; dump_data tracks the contents of that entry.
  - DONE: dump_done=1 and dump_busy=1 for exactly one cycle, then IDLE. dump_addr returns to 0.
- dump_start outside IDLE is ignored; it is not queued.
- A sweep never blocks reads or writes. Reads and writes proceed normally during SWEEP.
- A sweep takes at least DEPTH+1 cycles from dump_start to the dump_done pulse.
- All outputs are registered except dump_data.

Test Plan:
- Reset then idle:
  - Drive reset=1 for 2 cycles with we=1, wa=3, wd=32'hFFFF_FFFF.
  - Release reset; rd_en=1, ra={5'd3,5'd3}.
  - Required: rdata=0 both ports, rvalid=1 one edge later. Entry 3 stays 0, because the writes under reset were ignored.
- Write/read latency and hold:
  - Write wa=5, wd=32'hDEAD_BEEF.
  - Next cycle: rd_en=1, ra port0=5. Required: rdata0=32'hDEAD_BEEF after one edge, rvalid=1.
  - Next cycle: rd_en=0. Required: rvalid=0, rdata0 still 32'hDEAD_BEEF.
- Zero register and out of range (DEPTH=24):
  - Write wa=0, wd=7, then wa=30, wd=9.
  - Read ra={0,30}. Required: rdata={0,0}, and a full dump shows no entry equal to 7 or 9.
- Bypass:
  - Entry 8 holds 32'h1111.
  - Same cycle: we=1, wa=8, wd=32'h2222, rd_en=1, ra port1=8.
  - Required: rdata1=32'h2222 with BYPASS=1. With BYPASS=0, rdata1=32'h1111, and a re-read returns 32'h2222.
- Dump with backpressure:
  - Preload entry k = k*4 for k=1..31, pulse dump_start, toggle dump_ready 1,0,1,0...
  - Required: 32 accepted beats with dump_addr 0..31 in order and data 0,4,...,124. No index is skipped or repeated while ready=0. Exactly one dump_done pulse.
  - Required: a dump_start issued mid-sweep has no effect.
- Reset mid-sweep:
  - Assert reset while dump_addr=10.
  - Required: next cycle dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0. A new dump_start restarts from 0 with all entries reading 0.

Source files
------------

// File: rtl/regfile_mux_np.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_mux_np
// Purpose  : Register file with NUM_RD registered read ports. Each read port
//            has optional same-cycle write bypass and an optional hard-wired
//            zero at entry 0. A handshaked dump port walks every entry, one
//            entry per accepted beat.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            we/wa/wd         - write enable, address, data
//            rd_en/ra         - capture strobe, packed read addresses
//            rdata/rvalid     - packed registered read data, valid flag
//            dump_start       - request a full sweep (ignored unless idle)
//            dump_ready       - consumer accepts the current beat
//            dump_valid/addr  - beat present, entry index
//            dump_data        - entry contents (combinational)
//            dump_busy/done   - sweep in progress, end-of-sweep pulse
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mux_np #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic                     rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*WIDTH-1:0]  rdata,
    output logic                     rvalid,
    input  logic                     dump_start,
    input  logic                     dump_ready,
    output logic                     dump_valid,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [WIDTH-1:0]         dump_data,
    output logic                     dump_busy,
    output logic                     dump_done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SWEEP = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // One extra bit so DEPTH = 2**ADDR_W is representable in range checks.
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH-1);

    logic [WIDTH-1:0]             r_mem [DEPTH];
    logic                         w_wr_ok;
    logic [NUM_RD-1:0][WIDTH-1:0] w_rd_val;
    logic [NUM_RD-1:0][WIDTH-1:0] r_rdata;
    logic                         r_rvalid;

    logic [1:0]                   r_state;
    logic [1:0]                   w_state_nx;
    logic [ADDR_W-1:0]            r_dump_addr;
    logic [ADDR_W-1:0]            w_addr_nx;
    logic                         r_dump_valid;
    logic                         r_dump_busy;
    logic                         r_dump_done;
    logic                         w_accept;

    // A write only lands if it targets a real, writable entry; the same
    // qualifier gates bypass so an ignored write is never forwarded.
    assign w_wr_ok = we && ({1'b0, wa} < c_DEPTH) &&
                     !((ZERO_REG != 0) && (wa == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wa] <= wd;
        end
    end

    // Per-port read selector, priority: out of range, zero entry, bypass,
    // stored contents.
    generate
        for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic              w_ra_ok;
            logic              w_ra_zero;
            logic              w_ra_byp;

            assign w_ra      = ra[g*ADDR_W +: ADDR_W];
            assign w_ra_ok   = ({1'b0, w_ra} < c_DEPTH);
            assign w_ra_zero = (ZERO_REG != 0) && (w_ra == '0);
            assign w_ra_byp  = (BYPASS != 0) && w_wr_ok && (wa == w_ra);
            assign w_rd_val[g] = (!w_ra_ok || w_ra_zero) ? '0 :
                                 w_ra_byp                ? wd :
                                                           r_mem[w_ra];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= rd_en;
            if (rd_en) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

    // Dump sweep: next-state logic.
    assign w_accept = r_dump_valid && dump_ready;

    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_dump_addr;
        case (r_state)
            c_IDLE: begin
                if (dump_start) begin
                    w_state_nx = c_SWEEP;
                    w_addr_nx  = '0;
                end
            end
            c_SWEEP: begin
                if (w_accept) begin
                    if (r_dump_addr == c_LAST) begin
                        w_state_nx = c_DONE;
                        w_addr_nx  = '0;
                    end else begin
                        w_addr_nx = r_dump_addr + ADDR_W'(1);
                    end
                end
            end
            c_DONE: begin
                w_state_nx = c_IDLE;
                w_addr_nx  = '0;
            end
            default: begin
                w_state_nx = c_IDLE;
                w_addr_nx  = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_dump_addr  <= '0;
            r_dump_valid <= 1'b0;
            r_dump_busy  <= 1'b0;
            r_dump_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_dump_addr  <= w_addr_nx;
            r_dump_valid <= (w_state_nx == c_SWEEP);
            r_dump_busy  <= (w_state_nx != c_IDLE);
            r_dump_done  <= (w_state_nx == c_DONE);
        end
    end

    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_busy  = r_dump_busy;
    assign dump_done  = r_dump_done;
    assign dump_data  = ((ZERO_REG != 0) && (r_dump_addr == '0)) ? '0 :
                        r_mem[r_dump_addr];

endmodule
`default_nettype wire

// File: tb/tb_regfile_mux_np.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mux_np
// Purpose  : Self-checking bench for regfile_mux_np. Two instances share the
//            stimulus: inst 0 uses defaults (DEPTH=32, BYPASS=1), inst 1 uses
//            DEPTH=24, BYPASS=0. A behavioural model tracks both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mux_np;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rd_en;
    logic [9:0]  ra;
    logic        dump_start;
    logic        dump_ready;

    logic [63:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic        dv0, dv1;
    logic [4:0]  da0, da1;
    logic [31:0] dd0, dd1;
    logic        db0, db1;
    logic        ddone0, ddone1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mux_np #(
        .WIDTH(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) u_dut0 (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .rd_en(rd_en), .ra(ra), .rdata(rdata0), .rvalid(rvalid0),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dv0), .dump_addr(da0), .dump_data(dd0),
        .dump_busy(db0), .dump_done(ddone0)
    );

    regfile_mux_np #(
        .WIDTH(32), .DEPTH(24), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .rd_en(rd_en), .ra(ra), .rdata(rdata1), .rvalid(rvalid1),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dv1), .dump_addr(da1), .dump_data(dd1),
        .dump_busy(db1), .dump_done(ddone1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m    [2][32];
    logic [31:0] e_rd [2][2];
    logic        e_rv [2];
    logic        e_dv [2];
    logic        e_db [2];
    logic        e_dd [2];
    int          e_da [2];
    int          cfg_depth [2] = '{32, 24};
    int          cfg_byp   [2] = '{1, 0};
    bit          model_live = 0;

    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            if (reset) begin
                model_live = 1;
                for (int k = 0; k < 2; k++) begin
                    for (int j = 0; j < 32; j++) m[k][j] = '0;
                    e_rd[k][0] = '0; e_rd[k][1] = '0;
                    e_rv[k] = 0; e_dv[k] = 0; e_db[k] = 0; e_dd[k] = 0; e_da[k] = 0;
                end
            end else if (model_live) begin
                for (int k = 0; k < 2; k++) begin
                    bit          wok;
                    int          a;
                    logic [31:0] v;
                    wok = we && (int'(wa) < cfg_depth[k]) && (wa != 0);
                    for (int p = 0; p < 2; p++) begin
                        a = int'(ra[p*5 +: 5]);
                        if (a >= cfg_depth[k] || a == 0) v = '0;
                        else if (cfg_byp[k] == 1 && wok && int'(wa) == a) v = wd;
                        else v = m[k][a];
                        if (rd_en) e_rd[k][p] = v;
                    end
                    e_rv[k] = rd_en;
                    if (e_dd[k]) begin
                        e_dd[k] = 0; e_db[k] = 0;
                    end else if (e_dv[k]) begin
                        if (dump_ready) begin
                            if (e_da[k] == cfg_depth[k] - 1) begin
                                e_dv[k] = 0; e_dd[k] = 1; e_da[k] = 0;
                            end else begin
                                e_da[k]++;
                            end
                        end
                    end else if (dump_start) begin
                        e_dv[k] = 1; e_db[k] = 1; e_da[k] = 0;
                    end
                    if (wok) m[k][wa] = wd;
                end
            end
            @(negedge clk);
            if (model_live) begin
                chk("m0_rdata", rdata0, {e_rd[0][1], e_rd[0][0]});
                chk("m1_rdata", rdata1, {e_rd[1][1], e_rd[1][0]});
                chk("m0_rvalid", 64'(rvalid0), 64'(e_rv[0]));
                chk("m1_rvalid", 64'(rvalid1), 64'(e_rv[1]));
                chk("m0_dvalid", 64'(dv0), 64'(e_dv[0]));
                chk("m1_dvalid", 64'(dv1), 64'(e_dv[1]));
                chk("m0_dbusy", 64'(db0), 64'(e_db[0]));
                chk("m1_dbusy", 64'(db1), 64'(e_db[1]));
                chk("m0_ddone", 64'(ddone0), 64'(e_dd[0]));
                chk("m1_ddone", 64'(ddone1), 64'(e_dd[1]));
                chk("m0_daddr", 64'(da0), 64'(e_da[0]));
                chk("m1_daddr", 64'(da1), 64'(e_da[1]));
                if (e_dv[0]) chk("m0_ddata", 64'(dd0), 64'((e_da[0] == 0) ? 32'd0 : m[0][e_da[0]]));
                if (e_dv[1]) chk("m1_ddata", 64'(dd1), 64'((e_da[1] == 0) ? 32'd0 : m[1][e_da[1]]));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- directed + random stimulus ----------------
    int beats0, beats1, dones0, dones1;

    initial begin : stim
        reset = 1; we = 1; wa = 5'd3; wd = 32'hFFFF_FFFF;
        rd_en = 0; ra = '0; dump_start = 0; dump_ready = 0;
        repeat (2) @(negedge clk);

        // Reset then idle: writes under reset were ignored.
        reset = 0; we = 0; rd_en = 1; ra = {5'd3, 5'd3};
        @(negedge clk);
        chk("rst_rdata0", rdata0, 64'd0);
        chk("rst_rvalid0", 64'(rvalid0), 64'd1);
        chk("rst_rdata1", rdata1, 64'd0);

        // Write/read latency and hold.
        rd_en = 0; we = 1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 0; rd_en = 1; ra = {5'd0, 5'd5};
        @(negedge clk);
        chk("lat_rdata0", 64'(rdata0[31:0]), 64'hDEAD_BEEF);
        chk("lat_rvalid", 64'(rvalid0), 64'd1);
        rd_en = 0;
        @(negedge clk);
        chk("hold_rvalid", 64'(rvalid0), 64'd0);
        chk("hold_rdata0", 64'(rdata0[31:0]), 64'hDEAD_BEEF);

        // Zero register and out of range.
        we = 1; wa = 5'd0; wd = 32'd7;
        @(negedge clk);
        wa = 5'd30; wd = 32'd9;
        @(negedge clk);
        we = 0; rd_en = 1; ra = {5'd30, 5'd0};
        @(negedge clk);
        chk("oor_d24_rdata", rdata1, 64'd0);
        chk("oor_d32_rdata", rdata0, {32'd9, 32'd0});

        // Bypass vs no bypass.
        rd_en = 0; we = 1; wa = 5'd8; wd = 32'h1111;
        @(negedge clk);
        wd = 32'h2222; rd_en = 1; ra = {5'd8, 5'd0};
        @(negedge clk);
        chk("byp_on", 64'(rdata0[63:32]), 64'h2222);
        chk("byp_off", 64'(rdata1[63:32]), 64'h1111);
        we = 0;
        @(negedge clk);
        chk("byp_off_reread", 64'(rdata1[63:32]), 64'h2222);
        rd_en = 0;

        // Dump with backpressure and an ignored mid-sweep start.
        for (int k = 1; k < 32; k++) begin
            we = 1; wa = 5'(k); wd = 32'(k * 4);
            @(negedge clk);
        end
        we = 0; dump_start = 1;
        @(negedge clk);
        dump_start = 0;
        beats0 = 0; beats1 = 0; dones0 = 0; dones1 = 0;
        for (int c = 0; c < 120; c++) begin
            dump_ready = (c % 2 == 0);
            dump_start = (c == 20);
            if (dv0 && dump_ready) begin
                chk("dump0_addr", 64'(da0), 64'(beats0));
                chk("dump0_data", 64'(dd0), 64'(beats0 * 4));
                beats0++;
            end
            if (dv1 && dump_ready) begin
                chk("dump1_addr", 64'(da1), 64'(beats1));
                chk("dump1_data", 64'(dd1), 64'(beats1 * 4));
                beats1++;
            end
            if (ddone0) dones0++;
            if (ddone1) dones1++;
            @(negedge clk);
        end
        dump_ready = 0; dump_start = 0;
        chk("dump0_beats", 64'(beats0), 64'd32);
        chk("dump1_beats", 64'(beats1), 64'd24);
        chk("dump0_dones", 64'(dones0), 64'd1);
        chk("dump1_dones", 64'(dones1), 64'd1);
        chk("dump0_idle_after", 64'(db0), 64'd0);

        // Reset mid-sweep.
        dump_ready = 1; dump_start = 1;
        @(negedge clk);
        dump_start = 0;
        for (int c = 0; c < 40 && da0 != 5'd10; c++) @(negedge clk);
        chk("mid_addr10", 64'(da0), 64'd10);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mid_rst_valid", 64'(dv0), 64'd0);
        chk("mid_rst_busy", 64'(db0), 64'd0);
        chk("mid_rst_done", 64'(ddone0), 64'd0);
        chk("mid_rst_addr", 64'(da0), 64'd0);
        dump_start = 1;
        @(negedge clk);
        dump_start = 0;
        for (int c = 0; c < 6; c++) begin
            chk("restart_addr", 64'(da0), 64'(c));
            chk("restart_data", 64'(dd0), 64'd0);
            @(negedge clk);
        end
        dump_ready = 0;
        repeat (40) @(negedge clk);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 149) == 0);
            we         = $urandom_range(0, 1);
            wa         = 5'($urandom);
            wd         = $urandom;
            rd_en      = ($urandom_range(0, 3) != 0);
            ra         = ($urandom_range(0, 3) == 0) ? {wa, wa} : 10'($urandom);
            dump_start = ($urandom_range(0, 19) == 0);
            dump_ready = $urandom_range(0, 1);
            @(negedge clk);
        end
        reset = 0; we = 0; rd_en = 0; dump_start = 0; dump_ready = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
